// File: rtl/arbiter_2ph_pkg.sv
// Shared types and constants for the two-phase request/grant arbiter.
// The index-width helper keeps owner/pointer widths consistent across modules.
package arbiter_2ph_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbiter_pick.sv
// Combinational winner selection: lowest pending index (fixed) or first
// pending index at/after the pointer with wrap (round robin).
module arbiter_pick
    import arbiter_2ph_pkg::*;
#(
    parameter int  N    = 4,
    parameter int  MODE = MODE_RR,
    localparam int W    = idx_w(N)
) (
    input  logic [N-1:0] i_pending,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant_oh,
    output logic [W-1:0] o_grant_idx
);

    logic [W-1:0] w_start;
    logic [W:0]   w_sum;
    logic [W-1:0] w_cand;
    logic         w_found;

    // Fixed priority is the round-robin search with the start pinned at 0.
    assign w_start = (MODE == MODE_RR) ? i_ptr : '0;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < N; k++) begin
            w_sum  = {1'b0, w_start} + (W+1)'(k);
            w_cand = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : W'(w_sum);
            if (!w_found && i_pending[w_cand]) begin
                w_found             = 1'b1;
                o_grant_oh[w_cand]  = 1'b1;
                o_grant_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/arbiter_rn_2ph.sv
// N-channel arbiter with two-phase (transition-signalled) request, grant,
// done and acknowledge handshakes, optional input synchronisers.
//
// state | meaning
// IDLE  | no grant outstanding; next edge grants the winning pending channel
// BUSY  | owner holds the grant; waits until d_s[owner] matches g[owner]
module arbiter_rn_2ph
    import arbiter_2ph_pkg::*;
#(
    parameter int  N           = 4,
    parameter int  MODE        = MODE_RR,
    parameter int  SYNC_STAGES = 2,
    localparam int W           = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] r,
    output logic [N-1:0] a,
    output logic [N-1:0] g,
    input  logic [N-1:0] d,
    output logic [W-1:0] owner,
    output logic         busy,
    output logic         err
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("arbiter_rn_2ph: N=%0d outside 2..16", N);
    end
    if (MODE != MODE_FIXED && MODE != MODE_RR) begin : g_bad_mode
        $error("arbiter_rn_2ph: MODE=%0d must be 0 or 1", MODE);
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("arbiter_rn_2ph: SYNC_STAGES=%0d outside 0..3", SYNC_STAGES);
    end

    logic [N-1:0] w_r_s;
    logic [N-1:0] w_d_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_r_s = r;
        assign w_d_s = d;
    end else begin : g_sync
        logic [N-1:0] r_r_pipe [SYNC_STAGES];
        logic [N-1:0] r_d_pipe [SYNC_STAGES];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < SYNC_STAGES; s++) begin
                    r_r_pipe[s] <= '0;
                    r_d_pipe[s] <= '0;
                end
            end else begin
                r_r_pipe[0] <= r;
                r_d_pipe[0] <= d;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    r_r_pipe[s] <= r_r_pipe[s-1];
                    r_d_pipe[s] <= r_d_pipe[s-1];
                end
            end
        end

        assign w_r_s = r_r_pipe[SYNC_STAGES-1];
        assign w_d_s = r_d_pipe[SYNC_STAGES-1];
    end

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_a, w_a_nxt;
    logic [N-1:0] r_g, w_g_nxt;
    logic [W-1:0] r_owner, w_owner_nxt;
    logic [W-1:0] r_ptr, w_ptr_nxt;
    logic         r_err;

    logic [N-1:0] w_pending;
    logic [N-1:0] w_win_oh;
    logic [W-1:0] w_win_idx;
    logic [N-1:0] w_owner_oh;
    logic [N-1:0] w_mismatch;
    logic [W-1:0] w_ptr_inc;
    logic         w_release;
    logic         w_err_hit;

    assign w_pending  = w_r_s ^ r_a;
    assign w_owner_oh = {{(N-1){1'b0}}, 1'b1} << r_owner;
    assign w_mismatch = w_d_s ^ r_g;
    assign w_release  = (r_state == BUSY) && (w_d_s[r_owner] == r_g[r_owner]);
    assign w_ptr_inc  = (r_owner == W'(N-1)) ? '0 : r_owner + 1'b1;

    // Only the owner may legally have an outstanding grant; in IDLE none may.
    assign w_err_hit  = (r_state == BUSY) ? |(w_mismatch & ~w_owner_oh)
                                          : |w_mismatch;

    arbiter_pick #(
        .N    (N),
        .MODE (MODE)
    ) u_pick (
        .i_pending   (w_pending),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_win_oh),
        .o_grant_idx (w_win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_g     <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_g     <= w_g_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_err   <= r_err | w_err_hit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_g_nxt     = r_g;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (|w_pending) begin
                    w_g_nxt     = r_g ^ w_win_oh;
                    w_owner_nxt = w_win_idx;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_a_nxt     = r_a ^ w_owner_oh;
                    w_state_nxt = IDLE;
                    if (MODE == MODE_RR) begin
                        w_ptr_nxt = w_ptr_inc;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign a     = r_a;
    assign g     = r_g;
    assign owner = r_owner;
    assign busy  = (r_state == BUSY);
    assign err   = r_err;

endmodule

// File: doc/arbiter_rn_2ph.md
ARBITER_RN_2PH -- requirements
Module: arbiter_rn_2ph

Interface
REQ-001 Parameter N, default 4: number of channels, legal range 2..16.
REQ-002 Parameter MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-003 Parameter SYNC_STAGES, default 2: flop stages on r and d inputs, legal range 0..3.
REQ-004 clk  in  1  single clock; every flop in the block is clocked on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 r  in  N  per-channel 2-phase request; each transition is one request.
REQ-007 a  out  N  per-channel 2-phase acknowledge; a transition completes that channel's request.
REQ-008 g  out  N  per-channel 2-phase grant toward the shared resource.
REQ-009 d  in  N  per-channel 2-phase done from the resource; a transition releases the grant.
REQ-010 owner  out  max(1,$clog2(N))  index of the current grant holder; valid only while busy=1.
REQ-011 busy  out  1  high while a grant is outstanding.
REQ-012 err  out  1  sticky protocol-error flag.

Function
REQ-013 r and d SHALL pass through SYNC_STAGES flops each, giving r_s and d_s; with SYNC_STAGES=0 the raw inputs are used directly.
REQ-014 Channel i is pending when r_s[i] != a[i].
REQ-015 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-016 In IDLE with at least one channel pending, on the next edge the FSM SHALL:
  - pick a winner per MODE,
  - toggle g[winner],
  - load owner with the winner,
  - enter BUSY.
REQ-017 In IDLE with no channel pending, the FSM SHALL hold, with g and a unchanged.
REQ-018 In BUSY, on the edge at which d_s[owner] == g[owner], the FSM SHALL toggle a[owner] and enter IDLE; no grant is issued on that same edge.
REQ-019 In BUSY, all other pending channels SHALL wait; requests are never lost, only deferred.
REQ-020 Round robin: after each release the priority pointer SHALL become owner+1 modulo N, and the search SHALL start at the pointer and wrap from N-1 to 0.
REQ-021 Fixed priority: the lowest pending index SHALL win; the pointer is unused.
REQ-022 Simultaneous requests on the same edge SHALL be resolved by the MODE rule; exactly one g bit toggles.
REQ-023 Mutual exclusion: at most one i SHALL have g[i] != d_s[i] at any time.
REQ-024 A grant SHALL never be issued to a channel that is not pending.
REQ-025 Latency with SYNC_STAGES=0 is as follows; each sync stage adds one cycle to each path:
  - request to grant: one edge;
  - done to acknowledge: one edge;
  - minimum spacing between consecutive grants: two edges.
REQ-026 err SHALL set, and hold until reset, on any edge where d_s[j] != g[j] for some j other than the owner, or for any j while in IDLE.
REQ-027 A second r transition before the matching a transition is illegal. It is not detected, and its behaviour is undefined.

Reset
REQ-028 While rst=1, the following SHALL be forced asynchronously:
  - a=0, g=0;
  - FSM=IDLE, owner=0, busy=0;
  - round-robin pointer=0, err=0;
  - all sync flops=0.
REQ-029 Reset asserted mid-grant SHALL abandon the transaction. The environment SHALL also return r and d to 0 before deasserting reset.
REQ-030 Following deassertion, the first grant SHALL occur no earlier than the first rising edge after deassertion plus SYNC_STAGES cycles.

Structure
REQ-031 Package arbiter_2ph_pkg SHALL hold:
  - the state enum (IDLE, BUSY);
  - MODE constants MODE_FIXED=0 and MODE_RR=1.
REQ-032 The winner selection SHALL be a combinational sub-module, arbiter_pick, with parameters N and MODE:
  - inputs: pending vector and pointer;
  - outputs: one-hot winner and its index.
REQ-033 Illegal parameter values SHALL trigger an elaboration-time error.

Verification
The bench uses N=4 and SYNC_STAGES=0 unless a scenario states otherwise.
REQ-034 Single channel: r[2] goes 0->1 → next edge g[2]=1, owner=2, busy=1. Then d[2] goes 0->1 → next edge a[2]=1, busy=0.
REQ-035 Round-robin contention: r toggles on channels 0, 1 and 3 on the same edge → grant order 0, 1, 3. Each grant follows the previous done by two edges, and exactly one g bit toggles per grant.
REQ-036 Fixed priority (MODE=0): with channel 2 granted, r[0] and r[3] toggle → after d[2] the grant goes to 0, then to 3.
REQ-037 Wrap and second phase: with the pointer at 3, channels 3 and 0 pending, the grant order is 3 then 0. A 1->0 r transition on channel 3 is then granted by g[3] going 1->0.
REQ-038 Protocol error: d[1] toggles while channel 0 is owner → err=1 and stays 1 until rst is pulsed, after which all outputs are 0.
REQ-039 Synchroniser latency (SYNC_STAGES=2): r[0] toggles → g[0] toggles exactly three edges later. A randomised run of 10k transactions SHALL show no violation of REQ-023.
